uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the UART receiver. Captures each
//  9-bit word on the receiver's one-cycle done pulse and stores it in a FWFT FIFO.
//  Presents the words to the command logic over a valid/ready interface.
//  Tracks overflow and framing errors for status reporting.
// PARAMETERS
//  WIDTH    9   word width; must match the receiver data width
//  DEPTH    8   number of entries; must be a power of 2 and >= 2
//  ERR_W    8   width of the saturating framing-error counter
// PORTS
//  clock             in   1                   system clock
//  reset             in   1                   asynchronous, active-high reset
//  rx_data           in   WIDTH               receiver data word; sampled only when rx_done=1
//  rx_done           in   1                   one-cycle pulse: word complete, stop bit valid
//  rx_framing_error  in   1                   receiver framing error; may stay high several cycles
//  out_data          out  WIDTH               head-of-FIFO word; valid when out_valid=1
//  out_valid         out  1                   FIFO not empty
//  out_ready         in   1                   consumer accepts the head word this cycle
//  count             out  $clog2(DEPTH+1)     current occupancy, 0..DEPTH
//  overflow          out  1                   sticky: a word was dropped because the FIFO was full
//  frame_err         out  1                   sticky: a framing error was seen
//  frame_err_count   out  ERR_W               framing-error events, saturates at all-ones
//  clear_errors      in   1                   one-cycle pulse; clears overflow, frame_err and frame_err_count
// BEHAVIOUR
//  - Reset values (asynchronous): pointers=0, count=0, out_valid=0, overflow=0,
//    frame_err=0, frame_err_count=0. out_data=0 while empty after reset.
//    Storage contents are not reset.
//  - push = rx_done. pop = out_valid & out_ready.
//  - Push while not full: write rx_data at wr_ptr, then wr_ptr+1 (wraps modulo DEPTH).
//  - Latency: a word pushed into an empty FIFO in cycle N gives out_valid=1 and
//    out_data=word in cycle N+1. FWFT: out_data is a combinational read at rd_ptr.
//  - Pop: rd_ptr+1 (wraps). out_valid drops the cycle after the last word is popped.
//  - Push and pop in the same cycle:
//      - count is unchanged.
//      - When full, the push is accepted because the pop frees the slot. No overflow.
//      - When empty, the pop cannot occur (out_valid=0) and the push proceeds.
//  - Push while full with no pop: the word is discarded, overflow<=1, and pointers
//    and count are unchanged.
//  - out_ready is ignored when out_valid=0. out_data is held stable while
//    out_valid=1 and out_ready=0.
//  - Framing errors:
//      - An event is a rising edge of rx_framing_error (registered previous value,
//        reset 0).
//      - Each event sets frame_err and increments frame_err_count, which saturates
//        at 2^ERR_W-1.
//      - A multi-cycle high level counts as one event.
//      - No word is written on a framing error.
//  - clear_errors: clears all three error outputs next cycle. If a new error event
//    occurs in the same cycle, set wins: the flag is 1 and the count is 1.
//  - Reset mid-stream: all contents are abandoned. out_valid=0 immediately (async),
//    and the first word after reset lands in slot 0.
//  - count is always wr-rd occupancy. It never exceeds DEPTH and never underflows.
// TESTING
//  1. Reset, push 9'h0A5 -> out_valid=1 next cycle, out_data=9'h0A5, count=1; pop -> count=0, out_valid=0.
//  2. out_ready=0, push 9'h001..9'h008 -> count=8; push 9'h1FF -> overflow=1, count=8;
//     drain -> 001..008 in order, 1FF absent.
//  3. Full FIFO, push 9'h123 and pop in the same cycle -> overflow=0, count=8, 9'h123 read last.
//  4. rx_framing_error held high 5 cycles, twice -> frame_err=1, frame_err_count=2, count unchanged.
//  5. clear_errors in the same cycle as a framing-error rising edge -> frame_err=1, frame_err_count=1.
//  6. Push 20 words with out_ready random 50% -> output order matches input order across
//     pointer wrap; assert reset with count=3 -> count=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side word buffer behind the UART receiver: first-word-fall-through FIFO
// with valid/ready drain, plus sticky overflow and saturating framing-error status.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int ERR_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             rx_data,
  input  logic                         rx_done,
  input  logic                         rx_framing_error,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         frame_err,
  output logic [ERR_W-1:0]             frame_err_count,
  input  logic                         clear_errors
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             frame_lvl_p1;
  logic             frame_evt;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = rx_done & (~full | pop);
  assign drop      = rx_done & full & ~pop;
  assign frame_evt = rx_framing_error & ~frame_lvl_p1;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage is data only and carries no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      frame_lvl_p1    <= 1'b0;
      overflow        <= 1'b0;
      frame_err       <= 1'b0;
      frame_err_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      frame_lvl_p1 <= rx_framing_error;
      // On clear, a coincident new event still wins.
      if (clear_errors) begin
        overflow        <= drop;
        frame_err       <= frame_evt;
        frame_err_count <= ERR_W'(frame_evt);
      end else begin
        if (drop) overflow <= 1'b1;
        if (frame_evt) begin
          frame_err       <= 1'b1;
          frame_err_count <= sat_inc(frame_err_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the buffer and its status flags.
module tb_uart_rx_fifo;
  localparam int WIDTH = 9;
  localparam int DEPTH = 8;
  localparam int ERR_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] rx_data;
  logic             rx_done;
  logic             rx_framing_error;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       count;
  logic             overflow;
  logic             frame_err;
  logic [ERR_W-1:0] frame_err_count;
  logic             clear_errors;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] dut_pops[$];
  logic [WIDTH-1:0] sent[$];
  bit m_ovf, m_ferr, m_fe_prev;
  int m_fcnt;

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .rx_framing_error(rx_framing_error), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow), .frame_err(frame_err),
    .frame_err_count(frame_err_count), .clear_errors(clear_errors)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("out_data", 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("frame_err_count", 32'(frame_err_count), 32'(m_fcnt));
  endtask

  task automatic model_step();
    bit do_pop, ev, ovf_set;
    do_pop  = (q.size() > 0) && (out_ready === 1'b1);
    ovf_set = 0;
    if (do_pop) void'(q.pop_front());
    if (rx_done) begin
      if (q.size() < DEPTH) q.push_back(rx_data);
      else ovf_set = 1;
    end
    ev = rx_framing_error && !m_fe_prev;
    if (clear_errors) begin
      m_ovf  = ovf_set;
      m_ferr = ev;
      m_fcnt = ev ? 1 : 0;
    end else begin
      if (ovf_set) m_ovf = 1;
      if (ev) begin
        m_ferr = 1;
        m_fcnt = (m_fcnt >= (1 << ERR_W) - 1) ? m_fcnt : m_fcnt + 1;
      end
    end
    m_fe_prev = rx_framing_error;
  endtask

  task automatic cycle();
    if (out_valid && out_ready) dut_pops.push_back(out_data);
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input logic rdy);
    rx_data   = d;
    rx_done   = 1'b1;
    out_ready = rdy;
    cycle();
    rx_done   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data = '0; rx_done = 1'b0; rx_framing_error = 1'b0;
    out_ready = 1'b0; clear_errors = 1'b0;
    m_ovf = 0; m_ferr = 0; m_fe_prev = 0; m_fcnt = 0;
    #12;
    check_all();
    reset = 1'b0;

    // Single word round trip
    push_word(9'h0A5, 1'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h0A5);
    check("t1_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("t1_count_after_pop", 32'(count), 32'd0);
    check("t1_valid_after_pop", 32'(out_valid), 32'd0);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) push_word(9'(i), 1'b0);
    check("t2_full_count", 32'(count), 32'd8);
    push_word(9'h1FF, 1'b0);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_count_after_drop", 32'(count), 32'd8);
    dut_pops.delete();
    out_ready = 1'b1;
    repeat (9) cycle();
    out_ready = 1'b0;
    check("t2_pop_count", 32'(dut_pops.size()), 32'd8);
    for (int i = 0; i < dut_pops.size(); i++) check("t2_pop_order", 32'(dut_pops[i]), 32'(i + 1));
    check("t2_empty", 32'(out_valid), 32'd0);

    // Push and pop together while full
    clear_errors = 1'b1;
    cycle();
    clear_errors = 1'b0;
    check("t3_overflow_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) push_word(9'(9'h010 + i), 1'b0);
    push_word(9'h123, 1'b1);
    out_ready = 1'b0;
    check("t3_overflow", 32'(overflow), 32'd0);
    check("t3_count", 32'(count), 32'd8);
    dut_pops.delete();
    out_ready = 1'b1;
    repeat (8) cycle();
    out_ready = 1'b0;
    check("t3_pop_count", 32'(dut_pops.size()), 32'd8);
    check("t3_first", 32'(dut_pops[0]), 32'h011);
    check("t3_last", 32'(dut_pops[7]), 32'h123);

    // Long framing-error levels count once each
    for (int k = 0; k < 2; k++) begin
      rx_framing_error = 1'b1;
      repeat (5) cycle();
      rx_framing_error = 1'b0;
      repeat (3) cycle();
    end
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_frame_cnt", 32'(frame_err_count), 32'd2);
    check("t4_count", 32'(count), 32'd0);

    // Clear coinciding with a new event
    rx_framing_error = 1'b1;
    clear_errors = 1'b1;
    cycle();
    clear_errors = 1'b0;
    check("t5_frame_err", 32'(frame_err), 32'd1);
    check("t5_frame_cnt", 32'(frame_err_count), 32'd1);
    rx_framing_error = 1'b0;
    cycle();

    // Counter saturation
    repeat (260) begin
      rx_framing_error = 1'b1;
      cycle();
      rx_framing_error = 1'b0;
      cycle();
    end
    check("sat_frame_cnt", 32'(frame_err_count), 32'd255);
    clear_errors = 1'b1;
    cycle();
    clear_errors = 1'b0;
    check("sat_cleared", 32'(frame_err_count), 32'd0);

    // Random traffic across pointer wrap
    sent.delete();
    dut_pops.delete();
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] w;
      w = 9'($urandom_range(511));
      sent.push_back(w);
      push_word(w, 1'($urandom_range(1)));
      out_ready = 1'($urandom_range(1));
      cycle();
    end
    out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    out_ready = 1'b0;
    check("t6_drained", 32'(count), 32'd0);
    if (!m_ovf) begin
      check("t6_pop_total", 32'(dut_pops.size()), 32'd20);
      for (int i = 0; i < dut_pops.size() && i < 20; i++)
        check("t6_order", 32'(dut_pops[i]), 32'(sent[i]));
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) push_word(9'(9'h0C0 + i), 1'b0);
    check("t6_count3", 32'(count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_reset_count", 32'(count), 32'd0);
    check("t6_reset_valid", 32'(out_valid), 32'd0);
    q.delete();
    m_ovf = 0; m_ferr = 0; m_fcnt = 0; m_fe_prev = 0;
    check_all();
    #3;
    reset = 1'b0;
    push_word(9'h155, 1'b0);
    check("t6_post_reset_data", 32'(out_data), 32'h155);
    check("t6_post_reset_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("t6_final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
